// File: rtl/fan_pkg.sv
// Shared speed codes and FSM state encoding for the fan PWM ramp generator.
package fan_pkg;

    localparam logic [1:0] SPD_HIGH   = 2'b00;
    localparam logic [1:0] SPD_MEDIUM = 2'b01;
    localparam logic [1:0] SPD_LOW    = 2'b10;
    localparam logic [1:0] SPD_OFF    = 2'b11;

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_KICK = 2'b01,
        ST_RAMP = 2'b10,
        ST_HOLD = 2'b11
    } fan_state_t;

endpackage

// File: rtl/fan_pwm_ramp_pwm_core.sv
// Free-running PWM period counter with registered compare output and period tick.
module pwm_core #(
    parameter int unsigned PERIOD = 2000,
    localparam int unsigned CW    = $clog2(PERIOD + 1)
) (
    input  logic          clk_us,
    input  logic          rst_n,
    input  logic [CW-1:0] i_duty_nxt,
    output logic          o_pwm,
    output logic          o_tick
);

    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_pwm;

    always_comb begin
        w_cnt_nxt = (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
    end

    // Compare against next-cycle values so the flop output tracks cnt < duty_cur exactly.
    always_ff @(posedge clk_us or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_pwm <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_pwm <= (w_cnt_nxt < i_duty_nxt);
        end
    end

    assign o_pwm  = r_pwm;
    assign o_tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/fan_pwm_ramp.sv
// Fan PWM generator: speed code to duty with per-period slew limiting.
// Optional spin-up kick (full-on periods from OFF) enabled by defining FAN_KICK_EN.
module fan_pwm_ramp
    import fan_pkg::*;
#(
    parameter int unsigned PERIOD       = 2000,
    parameter int unsigned DUTY_HIGH    = 2000,
    parameter int unsigned DUTY_MED     = 1500,
    parameter int unsigned DUTY_LOW     = 1000,
    parameter int unsigned STEP         = 100,
    parameter int unsigned KICK_PERIODS = 4,
    localparam int unsigned CW          = $clog2(PERIOD + 1)
) (
    input  logic          clk_us,
    input  logic          rst_n,
    input  logic [1:0]    speed,
    output logic          speed_ctl,
    output logic [CW-1:0] duty_cur,
    output logic          ramping,
    output logic          period_tick
);

    localparam int unsigned   STEP_C    = (STEP > PERIOD) ? PERIOD : STEP;
    localparam logic [CW:0]   W_STEP    = (CW + 1)'(STEP_C);
    localparam logic [CW-1:0] DUTY_FULL = CW'(PERIOD);
    localparam logic [CW-1:0] T_HIGH    = CW'((DUTY_HIGH > PERIOD) ? PERIOD : DUTY_HIGH);
    localparam logic [CW-1:0] T_MED     = CW'((DUTY_MED  > PERIOD) ? PERIOD : DUTY_MED);
    localparam logic [CW-1:0] T_LOW     = CW'((DUTY_LOW  > PERIOD) ? PERIOD : DUTY_LOW);

    logic [1:0]    r_speed_q;
    logic [CW-1:0] r_duty;
    logic [CW-1:0] w_duty_nxt;
    logic [CW-1:0] w_target;
    logic [CW-1:0] w_step;
    logic [CW:0]   w_up;
    logic [CW:0]   w_dn_lim;
    fan_state_t    r_state;
    fan_state_t    w_state_nxt;
    fan_state_t    w_after_step;
    logic          w_tick;
    logic          w_pwm;

`ifdef FAN_KICK_EN
    localparam int unsigned KW = (KICK_PERIODS > 0) ? $clog2(KICK_PERIODS + 1) : 1;

    logic [KW-1:0] r_kick_cnt;
    logic [KW-1:0] w_kick_nxt;
    logic          w_kick_done;

    assign w_kick_done = (({1'b0, r_kick_cnt} + 1'b1) >= (KW + 1)'(KICK_PERIODS));

    always_ff @(posedge clk_us or negedge rst_n) begin
        if (!rst_n) r_kick_cnt <= '0;
        else        r_kick_cnt <= w_kick_nxt;
    end
`endif

    always_comb begin
        case (r_speed_q)
            SPD_HIGH:   w_target = T_HIGH;
            SPD_MEDIUM: w_target = T_MED;
            SPD_LOW:    w_target = T_LOW;
            default:    w_target = '0;
        endcase
    end

    // Slew one STEP toward target in CW+1 bits so neither direction wraps.
    always_comb begin
        w_up     = {1'b0, r_duty} + W_STEP;
        w_dn_lim = {1'b0, w_target} + W_STEP;
        w_step   = r_duty;
        if (r_duty < w_target)
            w_step = (w_up > {1'b0, w_target}) ? w_target : w_up[CW-1:0];
        else if (r_duty > w_target)
            w_step = ({1'b0, r_duty} > w_dn_lim) ? (r_duty - CW'(STEP_C)) : w_target;
    end

    always_comb begin
        if (w_step != w_target)  w_after_step = ST_RAMP;
        else if (w_target == '0) w_after_step = ST_OFF;
        else                     w_after_step = ST_HOLD;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
`ifdef FAN_KICK_EN
        w_kick_nxt  = r_kick_cnt;
`endif
        if (w_tick) begin
            case (r_state)
                ST_OFF: begin
                    if (w_target != '0) begin
`ifdef FAN_KICK_EN
                        w_state_nxt = ST_KICK;
                        w_duty_nxt  = DUTY_FULL;
                        w_kick_nxt  = '0;
`else
                        w_state_nxt = w_after_step;
                        w_duty_nxt  = w_step;
`endif
                    end
                end
`ifdef FAN_KICK_EN
                ST_KICK: begin
                    if ((w_target == '0) || w_kick_done) begin
                        w_state_nxt = w_after_step;
                        w_duty_nxt  = w_step;
                    end else begin
                        w_kick_nxt  = r_kick_cnt + 1'b1;
                    end
                end
`endif
                ST_RAMP, ST_HOLD: begin
                    w_state_nxt = w_after_step;
                    w_duty_nxt  = w_step;
                end
                default: begin
                    w_state_nxt = ST_OFF;
                    w_duty_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_us or negedge rst_n) begin
        if (!rst_n) begin
            r_speed_q <= SPD_OFF;
            r_duty    <= '0;
            r_state   <= ST_OFF;
        end else begin
            r_speed_q <= speed;
            r_duty    <= w_duty_nxt;
            r_state   <= w_state_nxt;
        end
    end

    pwm_core #(
        .PERIOD (PERIOD)
    ) u_pwm_core (
        .clk_us     (clk_us),
        .rst_n      (rst_n),
        .i_duty_nxt (w_duty_nxt),
        .o_pwm      (w_pwm),
        .o_tick     (w_tick)
    );

    assign speed_ctl   = w_pwm;
    assign duty_cur    = r_duty;
    assign period_tick = w_tick;
    assign ramping     = (r_state == ST_KICK) || (r_duty != w_target);

endmodule

// File: tb/tb_fan_pwm_ramp.sv
// Self-checking bench for fan_pwm_ramp against a per-period duty model; honours FAN_KICK_EN.
module tb_fan_pwm_ramp;

    localparam int P  = 20;
    localparam int DH = 20;
    localparam int DM = 15;
    localparam int DL = 10;
    localparam int ST = 5;
    localparam int KP = 2;
    localparam int CW = $clog2(P + 1);

    localparam logic [1:0] S_HIGH = 2'b00;
    localparam logic [1:0] S_MED  = 2'b01;
    localparam logic [1:0] S_LOW  = 2'b10;
    localparam logic [1:0] S_OFF  = 2'b11;

    logic          clk_us = 1'b0;
    logic          rst_n  = 1'b1;
    logic [1:0]    speed  = S_HIGH;
    logic          speed_ctl;
    logic [CW-1:0] duty_cur;
    logic          ramping;
    logic          period_tick;

    int checks   = 0;
    int failures = 0;

    always #5 clk_us = ~clk_us;

    fan_pwm_ramp #(
        .PERIOD       (P),
        .DUTY_HIGH    (DH),
        .DUTY_MED     (DM),
        .DUTY_LOW     (DL),
        .STEP         (ST),
        .KICK_PERIODS (KP)
    ) dut (
        .clk_us      (clk_us),
        .rst_n       (rst_n),
        .speed       (speed),
        .speed_ctl   (speed_ctl),
        .duty_cur    (duty_cur),
        .ramping     (ramping),
        .period_tick (period_tick)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int tgt(input logic [1:0] s);
        case (s)
            S_HIGH:  return DH;
            S_MED:   return DM;
            S_LOW:   return DL;
            default: return 0;
        endcase
    endfunction

    function automatic int step_to(input int d, input int t);
        if (d < t) return (d + ST > t) ? t : d + ST;
        if (d > t) return (d - ST < t) ? t : d - ST;
        return d;
    endfunction

    // Model: position in period, applied duty, remaining kick periods, registered speed.
    int         m_cnt;
    int         m_duty;
    int         m_kick;
    logic [1:0] m_sq;

    always @(posedge clk_us or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_duty <= 0;
            m_kick <= 0;
            m_sq   <= S_OFF;
        end else begin
            m_sq  <= speed;
            m_cnt <= (m_cnt == P - 1) ? 0 : m_cnt + 1;
            if (m_cnt == P - 1) begin
`ifdef FAN_KICK_EN
                if (m_kick > 0) begin
                    if (tgt(m_sq) == 0 || m_kick == 1) begin
                        m_kick <= 0;
                        m_duty <= step_to(m_duty, tgt(m_sq));
                    end else begin
                        m_kick <= m_kick - 1;
                    end
                end else if (m_duty == 0 && tgt(m_sq) != 0) begin
                    m_kick <= KP;
                    m_duty <= P;
                end else begin
                    m_duty <= step_to(m_duty, tgt(m_sq));
                end
`else
                m_duty <= step_to(m_duty, tgt(m_sq));
`endif
            end
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk_us) begin
        if (cmp_en) begin
            check("speed_ctl",   int'(speed_ctl),   int'(m_cnt < m_duty));
            check("duty_cur",    int'(duty_cur),    m_duty);
            check("period_tick", int'(period_tick), int'(m_cnt == P - 1));
            check("ramping",     int'(ramping),     int'((m_kick > 0) || (m_duty != tgt(m_sq))));
        end
    end

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk_us);
            n++;
        end while (!period_tick && n < 3 * P);
        check("tick_timeout", int'(period_tick), 1);
    endtask

    // Count high cycles over the next full period; optional mid-period speed changes at indices a, b.
    task automatic count_period(output int hi, input int a, input logic [1:0] va,
                                input int b, input logic [1:0] vb);
        hi = 0;
        for (int i = 0; i < P; i++) begin
            @(negedge clk_us);
            hi += int'(speed_ctl);
            if (i == a) speed = va;
            if (i == b) speed = vb;
        end
    endtask

    task automatic expect_periods(input string name, input int exp[$]);
        int hi;
        foreach (exp[k]) begin
            count_period(hi, -1, S_OFF, -1, S_OFF);
            check($sformatf("%s[%0d]", name, k), hi, exp[k]);
        end
    endtask

    initial begin
        int hi;
        int exp2[$];
        int exp5[$];
        int exp6[$];
        logic [1:0] spd2;
        int hold2;
`ifdef FAN_KICK_EN
        spd2 = S_MED;  hold2 = 15;
        exp2 = '{0, 20, 20, 15, 15};
        exp5 = '{0, 20, 20, 15, 10, 10};
        exp6 = '{20, 20, 20};
`else
        spd2 = S_LOW;  hold2 = 10;
        exp2 = '{0, 5, 10, 10};
        exp5 = '{0, 5, 10, 10, 10, 10};
        exp6 = '{5, 10, 15};
`endif

        // Reset held with HIGH requested.
        #1 rst_n = 1'b0;
        speed  = S_HIGH;
        cmp_en = 1'b1;
        repeat (5) @(negedge clk_us);
        check("rst_duty",  int'(duty_cur),  0);
        check("rst_pwm",   int'(speed_ctl), 0);
        check("rst_ramp",  int'(ramping),   0);

        // OFF after release: never a high cycle.
        rst_n = 1'b1;
        speed = S_OFF;
        hi = 0;
        repeat (100) begin
            @(negedge clk_us);
            hi += int'(speed_ctl);
        end
        check("off_quiet", hi, 0);

        // Spin-up from OFF.
        wait_tick();
        speed = spd2;
        expect_periods("spinup", exp2);
        check("spinup_ramping", int'(ramping),  0);
        check("spinup_duty",    int'(duty_cur), hold2);

        // Bring to HIGH steady.
        speed = S_HIGH;
        expect_periods("to_high", '{hold2, (hold2 + ST > 20) ? 20 : hold2 + ST, 20, 20});
        check("high_duty", int'(duty_cur), 20);

        // OFF requested at cnt=7: current period untouched, then ramp down.
        count_period(hi, 7, S_OFF, -1, S_OFF);
        check("off_req_period", hi, 20);
        expect_periods("rampdown", '{15, 10, 5, 0, 0});
        check("rampdown_duty", int'(duty_cur), 0);
        check("rampdown_ramp", int'(ramping),  0);

        // LOW steady, then LOW->HIGH->LOW within one period.
        speed = S_LOW;
        expect_periods("to_low", exp5);
        check("low_duty", int'(duty_cur), 10);
        count_period(hi, 3, S_HIGH, 9, S_LOW);
        check("glitch_period", hi, 10);
        count_period(hi, -1, S_OFF, -1, S_OFF);
        check("glitch_next", hi, 10);
        check("glitch_duty", int'(duty_cur), 10);
        check("glitch_ramp", int'(ramping),  0);

        // Async reset mid-ramp at duty 10.
        speed = S_HIGH;
        repeat (5) @(negedge clk_us);
        check("preclr_ramp", int'(ramping),  1);
        check("preclr_duty", int'(duty_cur), 10);
        #2 rst_n = 1'b0;
        #1;
        check("aclr_duty", int'(duty_cur),    0);
        check("aclr_pwm",  int'(speed_ctl),   0);
        check("aclr_ramp", int'(ramping),     0);
        check("aclr_tick", int'(period_tick), 0);
        repeat (2) @(negedge clk_us);
        rst_n = 1'b1;
        wait_tick();
        expect_periods("restart", exp6);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fan_pwm_ramp.md
Name: fan_pwm_ramp

Overview:
- Parametrised successor to the fixed 3-speed fan PWM generator.
- Generates the fan PWM from a 2-bit speed code.
- Period and per-level duties are parameters; duty slews toward the target by STEP once per period, so speed changes have no current spikes.
- Output is registered and glitch-free; duty changes only at period boundaries. Sits between the remote-command decoder and the fan driver pin.

Parameters:
- PERIOD, 2000: PWM period in clk_us cycles, >=2.
- DUTY_HIGH, 2000: high-level on-time in cycles, <=PERIOD.
- DUTY_MED, 1500: medium-level on-time.
- DUTY_LOW, 1000: low-level on-time.
- STEP, 100: max duty change per period, >=1.
- KICK_PERIODS, 4: full-on periods at spin-up. Used only with FAN_KICK_EN.

Ports:
- clk_us  input  1  1 MHz clock.
- rst_n  input  1  asynchronous active-low reset.
- speed  input  2  speed code: HIGH=00, MEDIUM=01, LOW=10, OFF=11.
- speed_ctl  output  1  PWM to the fan driver; registered.
- duty_cur  output  CW  duty currently applied, where CW=$clog2(PERIOD+1).
- ramping  output  1  high while duty_cur != target or in KICK.
- period_tick  output  1  one-cycle pulse when cnt==PERIOD-1.

Behaviour:
- Clock and reset: one clock, clk_us. Reset rst_n is asynchronous, active-low. All flops are cleared on reset.
- Reset values: cnt=0, duty_cur=0, state=OFF, speed_ctl=0, ramping=0, period_tick=0, speed_q=OFF.
- Speed input: speed is registered into speed_q every cycle. target = DUTY_HIGH / DUTY_MED / DUTY_LOW / 0 for HIGH / MEDIUM / LOW / OFF.
- Counter: cnt runs 0..PERIOD-1 and wraps to 0. Boundary = the cycle where cnt==PERIOD-1.
- Output comparison: speed_ctl is a flop loaded with (cnt_nxt < duty_nxt). It is therefore high exactly in the cycles where cnt < duty_cur.
  - duty 0 gives constant low. This fixes the old 1-cycle glitch at OFF.
  - duty PERIOD gives constant high.
- Update timing: duty_cur and state change only at a boundary. The new value is applied from cnt==0. Mid-period speed changes take effect at the next boundary.
- Ramp at each boundary:
  - If duty_cur < target: duty_cur = min(duty_cur+STEP, target).
  - If duty_cur > target: duty_cur = max(duty_cur-STEP, target), computed without underflow.
  - Arithmetic is CW+1 bits wide. Results are clamped to [0, PERIOD].
- FSM states: OFF, KICK, RAMP, HOLD.
  - OFF: duty_cur==0 and target==0. At a boundary with target!=0: go to KICK if the macro is set, else RAMP.
  - KICK: duty_cur=PERIOD. kick_cnt counts boundaries. After KICK_PERIODS boundaries, go to RAMP, which ramps down toward target. If target==OFF at any boundary in KICK, go to RAMP immediately, ramping toward 0.
  - RAMP: step as above. When duty_cur reaches target, go to HOLD, or to OFF if target==0.
  - HOLD: at a boundary with target!=duty_cur, go to RAMP.
- ramping is combinational from registers: (state==KICK) || (duty_cur != target).
- Reset mid-period or mid-ramp: everything returns to reset values immediately; no kick resumes.
- Target changed twice within one period: only speed_q at the boundary counts.

Optional Feature:
- Macro FAN_KICK_EN.
- Defined: spin-up from OFF goes through KICK, with KICK_PERIODS full-on periods, then ramps down to target. kick_cnt is a $clog2(KICK_PERIODS+1)-bit counter.
- Undefined: KICK state and kick_cnt are not built. OFF goes straight to RAMP from duty 0, and KICK_PERIODS is ignored.

Decomposition:
- Package fan_pkg holds:
  - speed codes SPD_HIGH=2'b00, SPD_MEDIUM=2'b01, SPD_LOW=2'b10, SPD_OFF=2'b11;
  - state encoding ST_OFF, ST_KICK, ST_RAMP, ST_HOLD (2 bits).
- One natural sub-module, pwm_core: free-running period counter, registered compare output and period_tick. The top level keeps the FSM, ramp arithmetic and target decode.

Test Plan:
Bench parameters: PERIOD=20, DUTY_HIGH=20, DUTY_MED=15, DUTY_LOW=10, STEP=5, KICK_PERIODS=2.
1. Reset held, speed=HIGH -> speed_ctl=0, duty_cur=0, cnt=0. After release with speed=OFF for 100 cycles -> speed_ctl stays 0, no glitch.
2. No macro, OFF->LOW -> duty_cur is 5 then 10 over successive periods. speed_ctl high 5 cycles then 10 cycles per period. ramping drops when duty_cur reaches 10; state HOLD.
3. FAN_KICK_EN, OFF->MEDIUM -> 2 periods at duty 20 (constant high), then 15, then HOLD.
4. HIGH steady, then speed=OFF mid-period at cnt=7 -> current period unchanged. Following periods show duty 15, 10, 5, 0, then state OFF.
5. LOW->HIGH->LOW toggled within one period, speed_q=LOW at the boundary -> duty_cur stays 10, no ramping.
6. rst_n asserted mid-ramp at duty 10 -> outputs clear the same cycle, asynchronously. After release, the ramp restarts from 0.
